ddr2_init_seq: RTL and testbench

DDR2_INIT_SEQ -- requirements
Module: ddr2_init_seq

---
 rtl/ddr2_init_pkg.sv | 40 ++++
 rtl/ddr2_init_dfi_if.sv | 15 +
 rtl/ddr2_init_timer.sv | 21 ++
 rtl/ddr2_init_seq.sv | 148 ++++++++++++++
 tb/tb_ddr2_init_seq.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/ddr2_init_pkg.sv
// Shared types and constants for the DDR2 power-up initialisation sequencer.
// OCD calibration states exist only when DDR2_INIT_OCD_EN is defined.
package ddr2_init_pkg;
   localparam int DRAM_ADDR_WIDTH = 14;
   localparam int DFI_BA_WIDTH    = 3;
   localparam int DFI_CS_WIDTH    = 1;
   localparam int TMR_W           = 16;

   typedef enum logic [3:0] {
      S_CKE_LOW,
      S_CKE_HIGH,
      S_PREA1,
      S_EMRS2,
      S_EMRS3,
      S_EMRS1_DLL,
      S_MRS_DLLRST,
      S_PREA2,
      S_REF1,
      S_REF2,
      S_MRS_RUN,
`ifdef DDR2_INIT_OCD_EN
      S_OCD_DFLT,
      S_OCD_EXIT,
`endif
      S_DLL_WAIT,
      S_DONE
   } state_e;

   // {cs_n, ras_n, cas_n, we_n}
   localparam logic [3:0] CMD_DESEL = 4'b1111;
   localparam logic [3:0] CMD_NOP   = 4'b0111;
   localparam logic [3:0] CMD_PREA  = 4'b0010;
   localparam logic [3:0] CMD_REF   = 4'b0001;
   localparam logic [3:0] CMD_MRS   = 4'b0000;

   localparam int MR_DLL_RST_BIT = 8;
   localparam int MR_OCD_LSB     = 7;
   localparam int MR_DLL_DIS_BIT = 0;
   localparam int PREA_ALL_BIT   = 10;
endpackage

// File: rtl/ddr2_init_dfi_if.sv
// Control-path bundle from the init sequencer toward the PHY.
interface DFI_CTRL_IF;
   import ddr2_init_pkg::*;
   logic                       cke;
   logic [DFI_CS_WIDTH-1:0]    cs_n;
   logic                       ras_n;
   logic                       cas_n;
   logic                       we_n;
   logic [DFI_BA_WIDTH-1:0]    ba;
   logic [DRAM_ADDR_WIDTH-1:0] addr;
   logic                       odt;

   modport SRC (output cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt);
   modport SNK (input  cke, cs_n, ras_n, cas_n, we_n, ba, addr, odt);
endinterface

// File: rtl/ddr2_init_timer.sv
// 16-bit loadable down-counter; expire marks the last cycle of a wait.
module ddr2_init_timer #(
   parameter logic [15:0] RST_VAL = 16'd1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load_i,
   input  logic [15:0] load_val_i,
   output logic        expire_o
);
   logic [15:0] cnt_q;

   // Parks at zero instead of wrapping once nothing reloads it.
   always_ff @(posedge clk) begin
      if (rst)               cnt_q <= RST_VAL;
      else if (load_i)       cnt_q <= load_val_i;
      else if (cnt_q != '0)  cnt_q <= cnt_q - 16'd1;
   end

   assign expire_o = (cnt_q == 16'd1);
endmodule

// File: rtl/ddr2_init_seq.sv
// DDR2 JEDEC power-up sequencer: CKE low, PREA, EMRS/MRS, refreshes, DLL lock.
// Define DDR2_INIT_OCD_EN to add the OCD default/exit EMRS pair.
module ddr2_init_seq
   import ddr2_init_pkg::*;
#(
   parameter int T_INIT_CKE_LOW = 40000,
   parameter int T_CKE_HIGH     = 80,
   parameter int T_RP           = 3,
   parameter int T_MRD          = 2,
   parameter int T_RFC          = 26,
   parameter int T_DLLK         = 200,
   parameter logic [DRAM_ADDR_WIDTH-1:0] MR_VAL   = 'h0432,
   parameter logic [DRAM_ADDR_WIDTH-1:0] EMR1_VAL = 'h0004,
   parameter logic [DRAM_ADDR_WIDTH-1:0] EMR2_VAL = '0,
   parameter logic [DRAM_ADDR_WIDTH-1:0] EMR3_VAL = '0
) (
   input  logic       clk,
   input  logic       rst,
   DFI_CTRL_IF.SRC    dfi_ctrl_if,
   output logic       init_busy,
   output logic       init_done
);
   localparam int AW = DRAM_ADDR_WIDTH;
   localparam logic [AW-1:0] OCD_MASK      = AW'(3'b111) << MR_OCD_LSB;
   localparam logic [AW-1:0] EMR1_DLL_ON   = EMR1_VAL & ~(AW'(1) << MR_DLL_DIS_BIT);
   localparam logic [AW-1:0] MR_DLL_RST    = MR_VAL | (AW'(1) << MR_DLL_RST_BIT);
   localparam logic [AW-1:0] MR_RUN        = MR_VAL & ~(AW'(1) << MR_DLL_RST_BIT);
   localparam logic [AW-1:0] EMR1_OCD_DFLT = EMR1_VAL | OCD_MASK;
   localparam logic [AW-1:0] EMR1_OCD_EXIT = EMR1_VAL & ~OCD_MASK;
   // The final MRS just hands over to DLL_WAIT, which absorbs the remaining tDLLK;
   // with tDLLK of one there is nothing left to wait so DONE follows directly.
   localparam state_e AFTER_LAST = (T_DLLK == 1) ? S_DONE : S_DLL_WAIT;

   state_e                  state_q, state_d;
   logic                    enter_q;
   logic                    load, expire;
   logic [TMR_W-1:0]        ld_val;
   logic                    cke_q, busy_q, done_q;
   logic [3:0]              cmd_q;
   logic [DFI_BA_WIDTH-1:0] ba_q;
   logic [AW-1:0]           addr_q;

   ddr2_init_timer #(.RST_VAL(16'(T_INIT_CKE_LOW))) u_timer (
      .clk        (clk),
      .rst        (rst),
      .load_i     (load),
      .load_val_i (ld_val),
      .expire_o   (expire)
   );

   always_comb begin
      state_d = state_q;
      if (expire) begin
         unique case (state_q)
            S_CKE_LOW:    state_d = S_CKE_HIGH;
            S_CKE_HIGH:   state_d = S_PREA1;
            S_PREA1:      state_d = S_EMRS2;
            S_EMRS2:      state_d = S_EMRS3;
            S_EMRS3:      state_d = S_EMRS1_DLL;
            S_EMRS1_DLL:  state_d = S_MRS_DLLRST;
            S_MRS_DLLRST: state_d = S_PREA2;
            S_PREA2:      state_d = S_REF1;
            S_REF1:       state_d = S_REF2;
            S_REF2:       state_d = S_MRS_RUN;
`ifdef DDR2_INIT_OCD_EN
            S_MRS_RUN:    state_d = S_OCD_DFLT;
            S_OCD_DFLT:   state_d = S_OCD_EXIT;
            S_OCD_EXIT:   state_d = AFTER_LAST;
`else
            S_MRS_RUN:    state_d = AFTER_LAST;
`endif
            S_DLL_WAIT:   state_d = S_DONE;
            default:      state_d = S_DONE;
         endcase
      end
   end

   // Each state loads the spacing that follows its own command.
   always_comb begin
      load   = (state_d != state_q);
      ld_val = 16'(T_MRD);
      unique case (state_d)
         S_CKE_HIGH:         ld_val = 16'(T_CKE_HIGH);
         S_PREA1, S_PREA2:   ld_val = 16'(T_RP);
         S_REF1, S_REF2:     ld_val = 16'(T_RFC);
`ifdef DDR2_INIT_OCD_EN
         S_OCD_EXIT:         ld_val = 16'd1;
`else
         S_MRS_RUN:          ld_val = 16'd1;
`endif
         S_DLL_WAIT:         ld_val = 16'(T_DLLK - 1);
         default:            ld_val = 16'(T_MRD);
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_CKE_LOW;
         enter_q <= 1'b0;
         cke_q   <= 1'b0;
         cmd_q   <= CMD_DESEL;
         ba_q    <= '0;
         addr_q  <= '0;
         busy_q  <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         enter_q <= load;
         cke_q   <= (state_q != S_CKE_LOW);
         cmd_q   <= (state_q == S_CKE_LOW) ? CMD_DESEL : CMD_NOP;
         ba_q    <= '0;
         addr_q  <= '0;
         busy_q  <= (state_q != S_DONE);
         done_q  <= (state_q == S_DONE);
         // Commands fire only on the first cycle after entry; the rest are NOP.
         if (enter_q) begin
            case (state_q)
               S_PREA1, S_PREA2: begin
                  cmd_q <= CMD_PREA;
                  addr_q[PREA_ALL_BIT] <= 1'b1;
               end
               S_REF1, S_REF2: cmd_q <= CMD_REF;
               S_EMRS2:      begin cmd_q <= CMD_MRS; ba_q <= 3'd2; addr_q <= EMR2_VAL;      end
               S_EMRS3:      begin cmd_q <= CMD_MRS; ba_q <= 3'd3; addr_q <= EMR3_VAL;      end
               S_EMRS1_DLL:  begin cmd_q <= CMD_MRS; ba_q <= 3'd1; addr_q <= EMR1_DLL_ON;   end
               S_MRS_DLLRST: begin cmd_q <= CMD_MRS; ba_q <= 3'd0; addr_q <= MR_DLL_RST;    end
               S_MRS_RUN:    begin cmd_q <= CMD_MRS; ba_q <= 3'd0; addr_q <= MR_RUN;        end
`ifdef DDR2_INIT_OCD_EN
               S_OCD_DFLT:   begin cmd_q <= CMD_MRS; ba_q <= 3'd1; addr_q <= EMR1_OCD_DFLT; end
               S_OCD_EXIT:   begin cmd_q <= CMD_MRS; ba_q <= 3'd1; addr_q <= EMR1_OCD_EXIT; end
`endif
               default: ;
            endcase
         end
      end
   end

   assign dfi_ctrl_if.cke   = cke_q;
   assign dfi_ctrl_if.cs_n  = {DFI_CS_WIDTH{cmd_q[3]}};
   assign dfi_ctrl_if.ras_n = cmd_q[2];
   assign dfi_ctrl_if.cas_n = cmd_q[1];
   assign dfi_ctrl_if.we_n  = cmd_q[0];
   assign dfi_ctrl_if.ba    = ba_q;
   assign dfi_ctrl_if.addr  = addr_q;
   assign dfi_ctrl_if.odt   = 1'b0;
   assign init_busy         = busy_q;
   assign init_done         = done_q;
endmodule

// File: tb/tb_ddr2_init_seq.sv
// Directed bench: nominal-timing DUT (a) and all-ones-timing DUT (b) checked cycle by cycle.
module tb_ddr2_init_seq;
   import ddr2_init_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy_a, done_a, busy_b, done_b;
   always #5 clk = ~clk;

   DFI_CTRL_IF dfi_a();
   DFI_CTRL_IF dfi_b();

   ddr2_init_seq #(
      .T_INIT_CKE_LOW(10), .T_CKE_HIGH(4), .T_RP(3), .T_MRD(2), .T_RFC(8), .T_DLLK(20),
      .MR_VAL(14'h0432), .EMR1_VAL(14'h0005), .EMR2_VAL(14'h0000), .EMR3_VAL(14'h0000)
   ) dut_a (
      .clk(clk), .rst(rst), .dfi_ctrl_if(dfi_a), .init_busy(busy_a), .init_done(done_a)
   );

   ddr2_init_seq #(
      .T_INIT_CKE_LOW(1), .T_CKE_HIGH(1), .T_RP(1), .T_MRD(1), .T_RFC(1), .T_DLLK(1),
      .MR_VAL(14'h0432), .EMR1_VAL(14'h0005), .EMR2_VAL(14'h0000), .EMR3_VAL(14'h0000)
   ) dut_b (
      .clk(clk), .rst(rst), .dfi_ctrl_if(dfi_b), .init_busy(busy_b), .init_done(done_b)
   );

   typedef struct packed {
      logic        cke;
      logic [3:0]  cmd;
      logic [2:0]  ba;
      logic [13:0] addr;
      logic        odt;
      logic        busy;
      logic        done;
   } obs_t;

   typedef struct {
      int          cyc_a;
      int          cyc_b;
      logic [3:0]  cmd;
      logic [2:0]  ba;
      logic [13:0] addr;
   } vec_t;

`ifdef DDR2_INIT_OCD_EN
   localparam int NCMD = 11, DONE_A = 68, DONE_B = 13;
`else
   localparam int NCMD = 9,  DONE_A = 64, DONE_B = 11;
`endif
   localparam int CKE_A = 10, CKE_B = 1;

   vec_t tbl [NCMD];
   int   n_cmp = 0;
   int   n_bad = 0;

   function automatic obs_t sample(bit b);
      obs_t o;
      if (b) o = '{dfi_b.cke, {&dfi_b.cs_n, dfi_b.ras_n, dfi_b.cas_n, dfi_b.we_n},
                   dfi_b.ba, dfi_b.addr, dfi_b.odt, busy_b, done_b};
      else   o = '{dfi_a.cke, {&dfi_a.cs_n, dfi_a.ras_n, dfi_a.cas_n, dfi_a.we_n},
                   dfi_a.ba, dfi_a.addr, dfi_a.odt, busy_a, done_a};
      return o;
   endfunction

   function automatic obs_t expect_at(int cyc, bit b);
      obs_t e;
      e      = '0;
      e.cke  = (cyc >= (b ? CKE_B : CKE_A));
      e.cmd  = e.cke ? CMD_NOP : CMD_DESEL;
      e.done = (cyc >= (b ? DONE_B : DONE_A));
      e.busy = !e.done;
      for (int i = 0; i < NCMD; i++) begin
         if (cyc == (b ? tbl[i].cyc_b : tbl[i].cyc_a)) begin
            e.cmd  = tbl[i].cmd;
            e.ba   = tbl[i].ba;
            e.addr = tbl[i].addr;
         end
      end
      return e;
   endfunction

   task automatic check(string tag, int cyc, bit b, obs_t exp);
      obs_t got;
      got = sample(b);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s dut_%s cyc=%0d got cke=%b cmd=%b ba=%0d addr=%h odt=%b busy=%b done=%b | want cke=%b cmd=%b ba=%0d addr=%h odt=%b busy=%b done=%b",
                  tag, b ? "b" : "a", cyc,
                  got.cke, got.cmd, got.ba, got.addr, got.odt, got.busy, got.done,
                  exp.cke, exp.cmd, exp.ba, exp.addr, exp.odt, exp.busy, exp.done);
      end
   endtask

   task automatic check_reset(string tag, int cyc);
      obs_t r;
      r = '{1'b0, CMD_DESEL, 3'd0, 14'h0, 1'b0, 1'b1, 1'b0};
      check(tag, cyc, 1'b0, r);
      check(tag, cyc, 1'b1, r);
   endtask

   // cycle 0 is the first posedge seen with rst low
   task automatic run(string tag, int last);
      for (int c = 0; c <= last; c++) begin
         @(posedge clk);
         @(negedge clk);
         check(tag, c, 1'b0, expect_at(c, 1'b0));
         check(tag, c, 1'b1, expect_at(c, 1'b1));
      end
   endtask

   initial begin
      tbl[0] = '{14,  2, CMD_PREA, 3'd0, 14'h0400};
      tbl[1] = '{17,  3, CMD_MRS,  3'd2, 14'h0000};
      tbl[2] = '{19,  4, CMD_MRS,  3'd3, 14'h0000};
      tbl[3] = '{21,  5, CMD_MRS,  3'd1, 14'h0004};
      tbl[4] = '{23,  6, CMD_MRS,  3'd0, 14'h0532};
      tbl[5] = '{25,  7, CMD_PREA, 3'd0, 14'h0400};
      tbl[6] = '{28,  8, CMD_REF,  3'd0, 14'h0000};
      tbl[7] = '{36,  9, CMD_REF,  3'd0, 14'h0000};
      tbl[8] = '{44, 10, CMD_MRS,  3'd0, 14'h0432};
`ifdef DDR2_INIT_OCD_EN
      tbl[9]  = '{46, 11, CMD_MRS, 3'd1, 14'h0385};
      tbl[10] = '{48, 12, CMD_MRS, 3'd1, 14'h0005};
`endif

      rst = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         @(negedge clk);
         check_reset("reset_hold", i);
      end

      // abort at the first REF of dut_a; dut_b is already in DONE here
      rst = 1'b0;
      run("seq_pre_abort", 28);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("mid_reset", 29);
      rst = 1'b0;

      // full restart; runs far enough to see dut_b hold done for 100+ cycles
      run("seq_full", DONE_B + 105);

      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check_reset("done_reset", 0);
      rst = 1'b0;
      run("seq_restart", 16);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
